// File: rtl/wb_port_arbiter_pkg.sv
// Shared pipeline definitions for the writeback-port arbiter.
package wb_port_arbiter_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop)
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline and a long-latency unit,
// tracking in-flight destinations in a scoreboard and requesting bubbles on starvation.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_W-1:0]      RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  issue_valid,
  input  logic [REG_W-1:0]      issue_rd,
  output logic                  issue_ready,
  input  logic                  llu_valid,
  input  logic [REG_W-1:0]      llu_rd,
  input  logic [DATA_WIDTH-1:0] llu_data,
  output logic                  llu_ready,
  input  logic [REG_W-1:0]      Rs1D,
  input  logic [REG_W-1:0]      Rs2D,
  input  logic [REG_W-1:0]      RdD,
  output logic                  StallLLU,
  output logic                  DrainReq,
  output logic                  RegWriteOut,
  output logic [REG_W-1:0]      RdOut,
  output logic [DATA_WIDTH-1:0] ResultOut
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_W-1:0]      rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [31:0]   pending_q, pending_d;
  logic [SW-1:0] starve_q, starve_d;
  entry_t        head, llu_entry;
  logic          fifo_full, fifo_empty;
  logic          pipe_wr, drain, push, issue_fire;

  assign pipe_wr    = RegWriteW && (RdW != '0);
  assign drain      = !rst && !pipe_wr && !fifo_empty;
  assign llu_ready  = rst || !fifo_full;
  assign push       = !rst && llu_valid && llu_ready && (llu_rd != '0);
  assign llu_entry  = '{rd: llu_rd, data: llu_data};
  // Pre-edge scoreboard: a same-cycle clear does not unblock an issue.
  assign issue_ready = rst || !pending_q[issue_rd];
  assign issue_fire  = !rst && issue_valid && issue_ready && (issue_rd != '0);
  assign StallLLU    = !rst && (pending_q[Rs1D] || pending_q[Rs2D] || pending_q[RdD]);
  assign DrainReq    = !rst && (starve_q == SW'(STARVE_LIMIT));

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (llu_entry),
    .pop_i   (drain),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    RegWriteOut = 1'b0;
    RdOut       = '0;
    ResultOut   = '0;
    if (pipe_wr) begin
      RegWriteOut = 1'b1;
      RdOut       = RdW;
      ResultOut   = ResultW;
    end else if (drain) begin
      RegWriteOut = 1'b1;
      RdOut       = head.rd;
      ResultOut   = head.data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (drain)      pending_d[head.rd]  = 1'b0;
    if (issue_fire) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Non-empty and not draining can only mean the pipeline held the port.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || drain)            starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      starve_q  <= '0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        StallLLU, DrainReq;
  logic        RegWriteOut;
  logic [4:0]  RdOut;
  logic [31:0] ResultOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .StallLLU(StallLLU), .DrainReq(DrainReq),
    .RegWriteOut(RegWriteOut), .RdOut(RdOut), .ResultOut(ResultOut)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h4444;
    tick(); tick();
    checks++;
    if ({issue_ready, llu_ready, StallLLU, DrainReq} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b exp 1100", {issue_ready, llu_ready, StallLLU, DrainReq});
    end
    checks++;
    if ({RegWriteOut, RdOut, ResultOut} !== {1'b1, 5'd4, 32'h4444}) begin
      errors++; $display("FAIL reset_pipe_pass: got %b %0d %h exp 1 4 4444", RegWriteOut, RdOut, ResultOut);
    end
    rst = 1'b0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = '0;
    tick();
    checks++;
    if ({RegWriteOut, RdOut, ResultOut} !== 38'd0) begin
      errors++; $display("FAIL reset_idle: got %b %0d %h exp 0 0 0", RegWriteOut, RdOut, ResultOut);
    end
  endtask

  task automatic test_basic();
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_issue_ready: got %b exp 1", issue_ready); end
    tick();
    issue_valid = 1'b0; Rs1D = 5'd5; #1;
    checks++;
    if ({StallLLU, issue_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_pending: got stall/ready %b exp 10", {StallLLU, issue_ready});
    end
    tick();
    llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 32'hDEADBEEF; #1;
    checks++;
    if ({llu_ready, RegWriteOut} !== 2'b10) begin
      errors++; $display("FAIL basic_no_bypass: got ready/wr %b exp 10", {llu_ready, RegWriteOut});
    end
    tick();
    llu_valid = 1'b0; #1;
    checks++;
    if ({RegWriteOut, RdOut, ResultOut, StallLLU} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL basic_write: got %b %0d %h stall %b exp 1 5 deadbeef 1", RegWriteOut, RdOut, ResultOut, StallLLU);
    end
    tick();
    checks++;
    if ({StallLLU, RegWriteOut} !== 2'b00) begin
      errors++; $display("FAIL basic_clear: got stall/wr %b exp 00", {StallLLU, RegWriteOut});
    end
    Rs1D = 5'd0;
  endtask

  task automatic test_starve();
    issue_valid = 1'b1; issue_rd = 5'd7; tick(); issue_valid = 1'b0;
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h7777; tick();
    llu_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if ({RegWriteOut, RdOut, ResultOut, DrainReq} !== {1'b1, 5'd3, 32'h33, (k == 5)}) begin
        errors++; $display("FAIL starve_cycle%0d: got %b %0d %h drain %b exp 1 3 33 %b", k, RegWriteOut, RdOut, ResultOut, DrainReq, (k == 5));
      end
      tick();
    end
    RegWriteW = 1'b0; RdW = 5'd0; #1;
    checks++;
    if ({RegWriteOut, RdOut, ResultOut, DrainReq} !== {1'b1, 5'd7, 32'h7777, 1'b1}) begin
      errors++; $display("FAIL starve_drain: got %b %0d %h drain %b exp 1 7 7777 1", RegWriteOut, RdOut, ResultOut, DrainReq);
    end
    tick();
    checks++;
    if ({DrainReq, RegWriteOut} !== 2'b00) begin
      errors++; $display("FAIL starve_release: got drain/wr %b exp 00", {DrainReq, RegWriteOut});
    end
  endtask

  task automatic test_full();
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
    issue_valid = 1'b1;
    issue_rd = 5'd10; tick();
    issue_rd = 5'd11; tick();
    issue_rd = 5'd12; tick();
    issue_valid = 1'b0;
    llu_valid = 1'b1;
    llu_rd = 5'd10; llu_data = 32'hA; tick();
    llu_rd = 5'd11; llu_data = 32'hB; tick();
    llu_rd = 5'd12; llu_data = 32'hC; #1;
    checks++;
    if (llu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b exp 0", llu_ready); end
    tick();
    RegWriteW = 1'b0; RdW = 5'd0; #1;
    checks++;
    if ({llu_ready, RegWriteOut, RdOut, ResultOut} !== {1'b0, 1'b1, 5'd10, 32'hA}) begin
      errors++; $display("FAIL full_drain1: got ready %b %b %0d %h exp 0 1 10 a", llu_ready, RegWriteOut, RdOut, ResultOut);
    end
    tick();
    checks++;
    if ({llu_ready, RegWriteOut, RdOut, ResultOut} !== {1'b1, 1'b1, 5'd11, 32'hB}) begin
      errors++; $display("FAIL full_push_pop: got ready %b %b %0d %h exp 1 1 11 b", llu_ready, RegWriteOut, RdOut, ResultOut);
    end
    tick();
    llu_valid = 1'b0; #1;
    checks++;
    if ({RegWriteOut, RdOut, ResultOut} !== {1'b1, 5'd12, 32'hC}) begin
      errors++; $display("FAIL full_third: got %b %0d %h exp 1 12 c", RegWriteOut, RdOut, ResultOut);
    end
    tick();
    checks++;
    if ({RegWriteOut, llu_ready} !== 2'b01) begin
      errors++; $display("FAIL full_empty: got wr/ready %b exp 01", {RegWriteOut, llu_ready});
    end
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9; tick(); issue_valid = 1'b0;
    llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h99; tick(); llu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; #1;
    checks++;
    if ({issue_ready, RegWriteOut, RdOut} !== {1'b0, 1'b1, 5'd9}) begin
      errors++; $display("FAIL same_block: got ready %b wr %b rd %0d exp 0 1 9", issue_ready, RegWriteOut, RdOut);
    end
    tick();
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_accept: got %b exp 1", issue_ready); end
    tick();
    issue_valid = 1'b0; Rs2D = 5'd9; #1;
    checks++;
    if (StallLLU !== 1'b1) begin errors++; $display("FAIL same_reset_pending: got %b exp 1", StallLLU); end
    Rs2D = 5'd0;
  endtask

  task automatic test_zero();
    llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h1234;
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h5678; #1;
    checks++;
    if ({RegWriteOut, RdOut, ResultOut, llu_ready} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL zero_same: got %b %0d %h ready %b exp 0 0 0 1", RegWriteOut, RdOut, ResultOut, llu_ready);
    end
    tick();
    llu_valid = 1'b0; RegWriteW = 1'b0; #1;
    checks++;
    if ({RegWriteOut, RdOut, ResultOut} !== 38'd0) begin
      errors++; $display("FAIL zero_no_enqueue: got %b %0d %h exp 0 0 0", RegWriteOut, RdOut, ResultOut);
    end
  endtask

  task automatic test_reset_flush();
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
    issue_valid = 1'b1;
    issue_rd = 5'd20; tick();
    issue_rd = 5'd21; tick();
    issue_valid = 1'b0;
    llu_valid = 1'b1;
    llu_rd = 5'd20; llu_data = 32'h20; tick();
    llu_rd = 5'd21; llu_data = 32'h21; tick();
    llu_valid = 1'b0; Rs1D = 5'd20; Rs2D = 5'd21; RdD = 5'd9; #1;
    checks++;
    if ({llu_ready, StallLLU} !== 2'b01) begin
      errors++; $display("FAIL flush_pre: got ready/stall %b exp 01", {llu_ready, StallLLU});
    end
    rst = 1'b1; RegWriteW = 1'b0; RdW = 5'd0; issue_rd = 5'd20; #1;
    checks++;
    if ({RegWriteOut, issue_ready, llu_ready, StallLLU, DrainReq} !== 5'b01100) begin
      errors++; $display("FAIL flush_during: got %b exp 01100", {RegWriteOut, issue_ready, llu_ready, StallLLU, DrainReq});
    end
    tick();
    rst = 1'b0; #1;
    checks++;
    if ({RegWriteOut, issue_ready, llu_ready, StallLLU, DrainReq} !== 5'b01100) begin
      errors++; $display("FAIL flush_after: got %b exp 01100", {RegWriteOut, issue_ready, llu_ready, StallLLU, DrainReq});
    end
    tick(); tick();
    checks++;
    if ({RegWriteOut, RdOut} !== 6'd0) begin
      errors++; $display("FAIL flush_no_stale: got %b %0d exp 0 0", RegWriteOut, RdOut);
    end
  endtask

  initial begin
    rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    issue_valid = 1'b0; issue_rd = '0; llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_same_cycle();
    test_zero();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
